core_if_ifu: RTL and testbench

CORE_IF_IFU -- requirements
Module: core_if_ifu

---
 rtl/core_if_ifu_pkg.sv | 47 ++++
 rtl/core_if_ifu_if.sv | 22 ++
 rtl/core_if_ibuf.sv | 68 ++++++
 rtl/core_if_ifu.sv | 115 +++++++++++
 tb/tb_core_if_ifu.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_if_ifu_pkg.sv
// Shared widths, opcodes, buffer entry layout and the static branch predictor
// used by the instruction fetch unit.
package core_if_ifu_pkg;

  localparam int CORE_PC_WIDTH   = 32;
  localparam int CORE_INST_WIDTH = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [CORE_PC_WIDTH-1:0]   pc;
    logic [CORE_INST_WIDTH-1:0] inst;
    logic                       predict;
  } ibuf_entry_t;

  typedef struct packed {
    logic                     taken;
    logic [CORE_PC_WIDTH-1:0] target;
  } predict_t;

  // JAL is always taken; conditional branches are taken only when backward.
  function automatic predict_t static_predict(input logic [CORE_INST_WIDTH-1:0] inst,
                                              input logic [CORE_PC_WIDTH-1:0]   pc);
    predict_t                 p;
    logic [CORE_PC_WIDTH-1:0] j_imm;
    logic [CORE_PC_WIDTH-1:0] b_imm;
    j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    case (inst[6:0])
      OPC_JAL: begin
        p.taken  = 1'b1;
        p.target = pc + j_imm;
      end
      OPC_BRANCH: begin
        p.taken  = inst[31];
        p.target = pc + b_imm;
      end
      default: begin
        p.taken  = 1'b0;
        p.target = pc + 32'd4;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/core_if_ifu_if.sv
// Instruction-memory fetch bus: the fetch unit is master, the memory is slave.
interface core_if_ifu_if;
  import core_if_ifu_pkg::*;

  logic                       o_ifetch_req_valid;
  logic                       i_ifetch_req_ready;
  logic [CORE_PC_WIDTH-1:0]   o_ifetch_req_addr;
  logic                       i_ifetch_rsp_valid;
  logic [CORE_INST_WIDTH-1:0] i_ifetch_rsp_inst;
  logic                       o_ifetch_rsp_ready;

  modport master (
    output o_ifetch_req_valid, o_ifetch_req_addr, o_ifetch_rsp_ready,
    input  i_ifetch_req_ready, i_ifetch_rsp_valid, i_ifetch_rsp_inst
  );

  modport slave (
    input  o_ifetch_req_valid, o_ifetch_req_addr, o_ifetch_rsp_ready,
    output i_ifetch_req_ready, i_ifetch_rsp_valid, i_ifetch_rsp_inst
  );

endinterface

// File: rtl/core_if_ibuf.sv
// Circular instruction buffer with synchronous clear; a push into a full
// buffer is accepted when a pop happens in the same cycle.
module core_if_ibuf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_pop_s;
  logic             do_push_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1'b1);
  endfunction

  assign do_pop_s  = pop & (count_r != {CW{1'b0}});
  assign do_push_s = push & ((count_r != FULL_CNT) | do_pop_s);
  assign head      = mem_r[rd_ptr_r];
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;

  // Entry storage; contents are only meaningful below count_r, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s & ~clr) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clr) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/core_if_ifu.sv
// Instruction fetch unit: issues in-order fetches, statically predicts
// branches at enqueue, and discards responses from abandoned paths.
module core_if_ifu
  import core_if_ifu_pkg::*;
#(
  parameter logic [CORE_PC_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
  parameter int                       BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  core_if_ifu_if.master              ifetch,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [CORE_PC_WIDTH-1:0]   o_pc,
  output logic [CORE_INST_WIDTH-1:0] o_inst,
  output logic                       o_branch_predict,
  input  logic                       i_pipe_flush_req,
  input  logic [CORE_PC_WIDTH-1:0]   i_flush_pc
);

  localparam int          CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  logic [CORE_PC_WIDTH-1:0] pc_r;
  logic [CORE_PC_WIDTH-1:0] tag_r;
  logic [CORE_PC_WIDTH-1:0] pc_nxt_s;
  logic [CORE_PC_WIDTH-1:0] tag_nxt_s;
  logic [CW-1:0]            outstanding_r;
  logic [CW-1:0]            discard_r;
  logic [CW-1:0]            outstanding_nxt_s;
  logic [CW-1:0]            discard_nxt_s;
  logic [CW-1:0]            buf_count_s;
  logic [CW:0]              inflight_s;
  logic                     req_fire_s;
  logic                     rsp_fire_s;
  logic                     rsp_take_s;
  logic                     redirect_s;
  logic                     buf_empty_s;
  predict_t                 pred_s;
  ibuf_entry_t              enq_entry_s;
  ibuf_entry_t              head_entry_s;

  // Requests in flight plus buffered entries never exceed the buffer depth,
  // which is what makes an unthrottled response path safe.
  assign inflight_s                = {1'b0, outstanding_r} + {1'b0, buf_count_s};
  assign ifetch.o_ifetch_req_valid = ~rst & (inflight_s < DEPTH_C);
  assign ifetch.o_ifetch_req_addr  = pc_r;
  assign ifetch.o_ifetch_rsp_ready = 1'b1;

  assign req_fire_s        = ifetch.o_ifetch_req_valid & ifetch.i_ifetch_req_ready;
  assign rsp_fire_s        = ifetch.i_ifetch_rsp_valid;
  assign rsp_take_s        = rsp_fire_s & (discard_r == {CW{1'b0}}) & ~i_pipe_flush_req;
  assign outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(rsp_fire_s);

  assign pred_s      = static_predict(ifetch.i_ifetch_rsp_inst, tag_r);
  assign redirect_s  = rsp_take_s & pred_s.taken;
  assign enq_entry_s = {tag_r, ifetch.i_ifetch_rsp_inst, pred_s.taken};

  // Next fetch PC, response tag and discard count; flush outranks prediction.
  always_comb begin
    pc_nxt_s      = pc_r;
    tag_nxt_s     = tag_r;
    discard_nxt_s = discard_r;
    if (i_pipe_flush_req) begin
      pc_nxt_s      = i_flush_pc;
      tag_nxt_s     = i_flush_pc;
      discard_nxt_s = outstanding_nxt_s;
    end else if (redirect_s) begin
      pc_nxt_s      = pred_s.target;
      tag_nxt_s     = pred_s.target;
      discard_nxt_s = outstanding_nxt_s;
    end else begin
      pc_nxt_s      = req_fire_s ? (pc_r + 32'd4) : pc_r;
      tag_nxt_s     = rsp_take_s ? (tag_r + 32'd4) : tag_r;
      discard_nxt_s = (rsp_fire_s && (discard_r != {CW{1'b0}})) ?
                      (discard_r - CW'(1'b1)) : discard_r;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      tag_r         <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
    end else begin
      pc_r          <= pc_nxt_s;
      tag_r         <= tag_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= discard_nxt_s;
    end
  end

  core_if_ibuf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(ibuf_entry_t))
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .clr       (i_pipe_flush_req),
    .push      (rsp_take_s),
    .push_data (enq_entry_s),
    .pop       (valid_out & ready_out),
    .head      (head_entry_s),
    .empty     (buf_empty_s),
    .count     (buf_count_s)
  );

  assign valid_out        = ~buf_empty_s & ~i_pipe_flush_req;
  assign o_pc             = head_entry_s.pc;
  assign o_inst           = head_entry_s.inst;
  assign o_branch_predict = head_entry_s.predict;

endmodule

// File: tb/tb_core_if_ifu.sv
// Random fetch/flush/reset stimulus against an architectural program-flow
// model; a negedge monitor pops the expected instruction stream.
module tb_core_if_ifu;
  import core_if_ifu_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_branch_predict;
  logic        i_pipe_flush_req;
  logic [31:0] i_flush_pc;

  core_if_ifu_if bus ();

  core_if_ifu #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ifetch           (bus),
    .valid_out        (valid_out),
    .ready_out        (ready_out),
    .o_pc             (o_pc),
    .o_inst           (o_inst),
    .o_branch_predict (o_branch_predict),
    .i_pipe_flush_req (i_pipe_flush_req),
    .i_flush_pc       (i_flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  exp_t        mon_e;
  logic [31:0] model_pc;
  int          compared = 0;
  int          mismatched = 0;
  int          delivered = 0;
  int          cycle = 0;
  int          first_req_cyc = 0;
  bit          first_req_pending = 1'b0;
  bit          want_latency = 1'b0;

  // Program image: a fixed loop head, then hashed filler with some branches.
  function automatic logic [31:0] tb_mem(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h8000_0000, 32'h8000_0004, 32'h8000_000C: return 32'h0000_0013;
      32'h8000_0008: return 32'hFE00_0CE3;   // beq x0,x0,-8
      default: ;
    endcase
    h = (a ^ 32'h5BD1_E995) * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    case (h[3:0])
      4'd0, 4'd1: return {h[31:9], 1'b0, h[7], 7'b1100011};
      4'd2:       return {h[31:22], 1'b0, h[20:7], 7'b1101111};
      default:    return {h[31:7], 7'b0010011};
    endcase
  endfunction

  // Architectural next PC under static prediction, using signed arithmetic.
  function automatic void model_next(input logic [31:0] pc, input logic [31:0] inst,
                                     output logic pred, output logic [31:0] nxt);
    int imm;
    pred = 1'b0;
    nxt  = pc + 32'd4;
    if (inst[6:0] == 7'b1101111) begin
      imm  = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096 +
             int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      pred = 1'b1;
      nxt  = pc + 32'(imm);
    end else if (inst[6:0] == 7'b1100011 && inst[31]) begin
      imm  = -4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
      pred = 1'b1;
      nxt  = pc + 32'(imm);
    end
  endfunction

  task automatic extend(input int n);
    exp_t        e;
    logic [31:0] nxt;
    for (int i = 0; i < n; i++) begin
      e.pc   = model_pc;
      e.inst = tb_mem(model_pc);
      model_next(e.pc, e.inst, e.pred, nxt);
      exp_q.push_back(e);
      model_pc = nxt;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    model_pc = pc;
    extend(16);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // One clock: sample at negedge, then act as memory and driver after posedge.
  task automatic step(input bit rnd);
    bit          hs;
    logic [31:0] addr;
    mreq_t       m;
    int          pend;
    @(negedge clk);
    hs   = bus.o_ifetch_req_valid & bus.i_ifetch_req_ready;
    addr = bus.o_ifetch_req_addr;
    if (rst) begin
      check("reset_req_valid", {31'd0, bus.o_ifetch_req_valid}, 32'd0);
      check("reset_valid_out", {31'd0, valid_out}, 32'd0);
      check("reset_req_addr", addr, RESET_PC);
    end else begin
      pend = mem_q.size() + (bus.i_ifetch_rsp_valid ? 1 : 0);
      check("outstanding_limit", {31'd0, pend <= BUF_DEPTH}, 32'd1);
      check("rsp_ready_const", {31'd0, bus.o_ifetch_rsp_ready}, 32'd1);
      if (hs) check("req_addr_aligned", {30'd0, addr[1:0]}, 32'd0);
      if (first_req_pending) begin
        first_req_pending = 1'b0;
        check("first_req_valid", {31'd0, bus.o_ifetch_req_valid}, 32'd1);
        check("first_req_addr", addr, RESET_PC);
        first_req_cyc = cycle;
      end
      if (want_latency && valid_out) begin
        want_latency = 1'b0;
        check("first_valid_latency", 32'(cycle - first_req_cyc), 32'd2);
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    if (hs) begin
      m.addr = addr;
      m.due  = cycle + (rnd ? int'($urandom_range(3, 1)) : 1) - 1;
      mem_q.push_back(m);
    end
    if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
      m = mem_q.pop_front();
      bus.i_ifetch_rsp_valid = 1'b1;
      bus.i_ifetch_rsp_inst  = tb_mem(m.addr);
    end else begin
      bus.i_ifetch_rsp_valid = 1'b0;
      bus.i_ifetch_rsp_inst  = $urandom();
    end
    if (rnd) begin
      bus.i_ifetch_req_ready = ($urandom_range(3, 0) != 0);
      ready_out        = ((cycle % 40) >= 5) && ($urandom_range(3, 0) != 0);
      i_pipe_flush_req = ($urandom_range(24, 0) == 0);
      if (i_pipe_flush_req) begin
        i_flush_pc = ($urandom_range(3, 0) == 0) ? 32'h8000_0100 :
                     32'h8000_0000 + 32'($urandom_range(255, 0)) * 32'd4;
        restart(i_flush_pc);
      end else begin
        i_flush_pc = $urandom();
      end
    end
  endtask

  // Scoreboard monitor: every decode handshake must match the model stream.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_pipe_flush_req) check("valid_out_during_flush", {31'd0, valid_out}, 32'd0);
      if (valid_out && ready_out) begin
        if (exp_q.size() < 2) extend(16);
        mon_e = exp_q.pop_front();
        check("deliver_pc", o_pc, mon_e.pc);
        check("deliver_inst", o_inst, mon_e.inst);
        check("deliver_predict", {31'd0, o_branch_predict}, {31'd0, mon_e.pred});
        delivered++;
      end
    end
  end

  initial begin
    rst                    = 1'b1;
    bus.i_ifetch_req_ready = 1'b0;
    bus.i_ifetch_rsp_valid = 1'b0;
    bus.i_ifetch_rsp_inst  = 32'd0;
    ready_out              = 1'b0;
    i_pipe_flush_req       = 1'b0;
    i_flush_pc             = 32'd0;
    model_pc               = RESET_PC;
    repeat (3) step(1'b0);

    // Always-ready memory with single-cycle responses through the loop head.
    rst = 1'b0;
    restart(RESET_PC);
    bus.i_ifetch_req_ready = 1'b1;
    ready_out              = 1'b1;
    first_req_pending      = 1'b1;
    want_latency           = 1'b1;
    repeat (16) step(1'b0);

    repeat (3000) step(1'b1);

    // Reset while requests are in flight; stale responses arrive during reset.
    for (int i = 0; i < 200 && mem_q.size() < 2; i++) step(1'b1);
    rst              = 1'b1;
    i_pipe_flush_req = 1'b0;
    repeat (6) step(1'b0);
    mem_q.delete();
    rst = 1'b0;
    restart(RESET_PC);
    first_req_pending = 1'b1;
    repeat (1500) step(1'b1);

    check("delivered_enough", {31'd0, delivered > 200}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
